mem_stage: RTL and testbench

- MEM pipeline stage. It is the consumer end of the EX->MEM valid/ready handshake.
- It accepts one instruction at a time from the EX->MEM register, issues the data-SRAM request for loads and stores, and captures load data.
- It presents the completed result to the WB stage through a registered valid/ready output.
- It sits between the EX->MEM register and the WB stage.

---
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: EX->MEM handshake, data-SRAM access, registered WB output.
// Optional forwarding ports are enabled by defining MEM_STAGE_FWD_EN.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] mem_alu_res,
    input  logic [DATA_W-1:0] mem_mem_wdata,
    input  logic [4:0]        mem_rf_waddr,
    input  logic              mem_rf_we,
    input  logic              mem_res_from_mem,
    input  logic              mem_mem_we,
    input  logic [31:0]       mem_pc,
    input  logic [31:0]       mem_inst,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    output logic [3:0]        data_sram_wstrb,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [DATA_W-1:0] wb_rf_wdata,
    output logic [4:0]        wb_rf_waddr,
    output logic              wb_rf_we,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_inst
`ifdef MEM_STAGE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [4:0]        fwd_waddr,
    output logic [DATA_W-1:0] fwd_wdata,
    output logic              fwd_pending
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t state, state_nx;
    logic   accept;
    logic   resp_done;
    logic   new_is_mem;

    logic [ADDR_W-1:0] r_alu_res;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_rf_waddr;
    logic              r_rf_we;
    logic              r_res_from_mem;
    logic              r_mem_we;
    logic [31:0]       r_pc;
    logic [31:0]       r_inst;

    assign o_mem_ready = (state == S_IDLE) | ((state == S_HOLD) & i_wb_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        resp_done  = 1'b0;
        accept     = i_mem_valid & o_mem_ready;
        new_is_mem = mem_res_from_mem | mem_mem_we;
        case (state)
            S_IDLE: if (accept) state_nx = new_is_mem ? S_REQ : S_HOLD;
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    if (data_sram_data_ok) begin
                        state_nx  = S_HOLD;
                        resp_done = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    state_nx  = S_HOLD;
                    resp_done = 1'b1;
                end
            end
            S_HOLD: begin
                if (accept)          state_nx = new_is_mem ? S_REQ : S_HOLD;
                else if (i_wb_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Result defaults to the ALU value; a returning load overwrites it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_res      <= '0;
            r_wdata        <= '0;
            r_result       <= '0;
            r_rf_waddr     <= '0;
            r_rf_we        <= 1'b0;
            r_res_from_mem <= 1'b0;
            r_mem_we       <= 1'b0;
            r_pc           <= '0;
            r_inst         <= '0;
        end else if (accept) begin
            r_alu_res      <= mem_alu_res;
            r_wdata        <= mem_mem_wdata;
            r_result       <= DATA_W'(mem_alu_res);
            r_rf_waddr     <= mem_rf_waddr;
            r_rf_we        <= mem_rf_we;
            r_res_from_mem <= mem_res_from_mem;
            r_mem_we       <= mem_mem_we;
            r_pc           <= mem_pc;
            r_inst         <= mem_inst;
        end else if (resp_done && r_res_from_mem) begin
            r_result <= data_sram_rdata;
        end
    end

    assign data_sram_req   = (state == S_REQ);
    assign data_sram_wr    = data_sram_req & r_mem_we;
    assign data_sram_addr  = data_sram_req ? r_alu_res : '0;
    assign data_sram_wdata = data_sram_req ? r_wdata : '0;
    assign data_sram_wstrb = data_sram_wr ? 4'hf : 4'h0;

    // Stores never write the register file, whatever rf_we EX supplied.
    assign o_wb_valid  = (state == S_HOLD);
    assign wb_rf_wdata = r_result;
    assign wb_rf_waddr = r_rf_waddr;
    assign wb_rf_we    = o_wb_valid & r_rf_we & ~r_mem_we;
    assign wb_pc       = r_pc;
    assign wb_inst     = r_inst;

`ifdef MEM_STAGE_FWD_EN
    logic busy;
    assign busy        = (state != S_IDLE);
    assign fwd_valid   = busy & r_rf_we & ~r_mem_we;
    assign fwd_waddr   = fwd_valid ? r_rf_waddr : 5'd0;
    assign fwd_wdata   = fwd_valid ? r_result : '0;
    assign fwd_pending = ((state == S_REQ) | (state == S_WAIT)) & r_res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        i_mem_valid;
    logic        o_mem_ready;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_mem_wdata;
    logic [4:0]  mem_rf_waddr;
    logic        mem_rf_we;
    logic        mem_res_from_mem;
    logic        mem_mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [31:0] wb_rf_wdata;
    logic [4:0]  wb_rf_waddr;
    logic        wb_rf_we;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .mem_alu_res(mem_alu_res), .mem_mem_wdata(mem_mem_wdata),
        .mem_rf_waddr(mem_rf_waddr), .mem_rf_we(mem_rf_we),
        .mem_res_from_mem(mem_res_from_mem), .mem_mem_we(mem_mem_we),
        .mem_pc(mem_pc), .mem_inst(mem_inst),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .wb_rf_wdata(wb_rf_wdata), .wb_rf_waddr(wb_rf_waddr), .wb_rf_we(wb_rf_we),
        .wb_pc(wb_pc), .wb_inst(wb_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        i_mem_valid       = 1'b0;
        mem_alu_res       = '0;
        mem_mem_wdata     = '0;
        mem_rf_waddr      = '0;
        mem_rf_we         = 1'b0;
        mem_res_from_mem  = 1'b0;
        mem_mem_we        = 1'b0;
        mem_pc            = '0;
        mem_inst          = '0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        i_wb_ready        = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        total++; if (o_mem_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", o_mem_ready); end
        total++; if ({o_wb_valid, data_sram_req, data_sram_wstrb, wb_rf_wdata, wb_rf_we} !== 39'h0) begin
            bad++; $display("FAIL reset_outputs valid=%b req=%b wstrb=%h wdata=%h we=%b want all 0",
                            o_wb_valid, data_sram_req, data_sram_wstrb, wb_rf_wdata, wb_rf_we);
        end
        rst = 1'b1;
        // load into WAIT, then pull reset asynchronously mid-cycle
        @(negedge clk);
        i_mem_valid = 1'b1; mem_res_from_mem = 1'b1; mem_alu_res = 32'h100; mem_rf_we = 1'b1; mem_rf_waddr = 5'd3;
        @(negedge clk);
        drive_idle(); data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        #1;
        total++; if ({data_sram_req, o_mem_ready, o_wb_valid} !== 3'b000) begin
            bad++; $display("FAIL wait_state req=%b ready=%b valid=%b want 000", data_sram_req, o_mem_ready, o_wb_valid);
        end
        #1 rst = 1'b0;
        #1;
        total++; if ({o_mem_ready, o_wb_valid, data_sram_req} !== 3'b100) begin
            bad++; $display("FAIL async_reset ready=%b valid=%b req=%b want 100", o_mem_ready, o_wb_valid, data_sram_req);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu();
        drive_idle();
        @(negedge clk);
        i_mem_valid = 1'b1; mem_alu_res = 32'h12345678; mem_rf_waddr = 5'd5; mem_rf_we = 1'b1;
        mem_pc = 32'h1c000000; mem_inst = 32'h00000013;
        #1;
        total++; if (o_mem_ready !== 1'b1) begin bad++; $display("FAIL alu_ready got %b want 1", o_mem_ready); end
        @(negedge clk);
        drive_idle();
        total++; if ({o_wb_valid, wb_rf_wdata, wb_rf_waddr, wb_rf_we, wb_pc} !== {1'b1, 32'h12345678, 5'd5, 1'b1, 32'h1c000000}) begin
            bad++; $display("FAIL alu_result valid=%b wdata=%h waddr=%0d we=%b pc=%h want 1 12345678 5 1 1c000000",
                            o_wb_valid, wb_rf_wdata, wb_rf_waddr, wb_rf_we, wb_pc);
        end
        @(negedge clk);
        total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL alu_release got %b want 0", o_wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h11110001; vals[1] = 32'h22220002; vals[2] = 32'h33330003;
        drive_idle();
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                total++; if ({o_wb_valid, wb_rf_wdata, wb_rf_waddr} !== {1'b1, vals[k-1], 5'(k)}) begin
                    bad++; $display("FAIL b2b_%0d valid=%b wdata=%h waddr=%0d want 1 %h %0d", k, o_wb_valid, wb_rf_wdata, wb_rf_waddr, vals[k-1], k);
                end
            end
            if (k < 3) begin
                i_mem_valid = 1'b1; mem_alu_res = vals[k]; mem_rf_waddr = 5'(k + 1); mem_rf_we = 1'b1;
                #1;
                total++; if (o_mem_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got %b want 1", k, o_mem_ready); end
            end else begin
                drive_idle();
            end
        end
        @(negedge clk);
        total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got %b want 0", o_wb_valid); end
    endtask

    task automatic test_load();
        drive_idle();
        @(negedge clk);
        i_mem_valid = 1'b1; mem_res_from_mem = 1'b1; mem_alu_res = 32'h1c; mem_rf_waddr = 5'd7; mem_rf_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_idle();
            if (k == 1) data_sram_addr_ok = 1'b1;
            #1;
            total++; if ({data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb, o_mem_ready} !== {1'b1, 32'h1c, 1'b0, 4'h0, 1'b0}) begin
                bad++; $display("FAIL load_req_%0d req=%b addr=%h wr=%b wstrb=%h ready=%b want 1 1c 0 0 0",
                                k, data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb, o_mem_ready);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            if (k == 2) begin data_sram_data_ok = 1'b1; data_sram_rdata = 32'hdeadbeef; end
            #1;
            total++; if ({data_sram_req, o_mem_ready, o_wb_valid} !== 3'b000) begin
                bad++; $display("FAIL load_wait_%0d req=%b ready=%b valid=%b want 000", k, data_sram_req, o_mem_ready, o_wb_valid);
            end
        end
        @(negedge clk);
        drive_idle();
        total++; if ({o_wb_valid, wb_rf_wdata, wb_rf_waddr, wb_rf_we} !== {1'b1, 32'hdeadbeef, 5'd7, 1'b1}) begin
            bad++; $display("FAIL load_result valid=%b wdata=%h waddr=%0d we=%b want 1 deadbeef 7 1", o_wb_valid, wb_rf_wdata, wb_rf_waddr, wb_rf_we);
        end
        @(negedge clk);
    endtask

    task automatic test_store();
        drive_idle();
        @(negedge clk);
        i_mem_valid = 1'b1; mem_mem_we = 1'b1; mem_alu_res = 32'h40; mem_mem_wdata = 32'ha5a5a5a5; mem_rf_we = 1'b1; mem_rf_waddr = 5'd9;
        @(negedge clk);
        drive_idle();
        total++; if ({data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata} !== {1'b1, 1'b1, 4'hf, 32'h40, 32'ha5a5a5a5}) begin
            bad++; $display("FAIL store_req req=%b wr=%b wstrb=%h addr=%h wdata=%h want 1 1 f 40 a5a5a5a5",
                            data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata);
        end
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12121212;
        @(negedge clk);
        drive_idle();
        total++; if ({o_wb_valid, wb_rf_we, data_sram_req} !== 3'b100) begin
            bad++; $display("FAIL store_hold valid=%b we=%b req=%b want 100", o_wb_valid, wb_rf_we, data_sram_req);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        drive_idle();
        @(negedge clk);
        i_mem_valid = 1'b1; mem_alu_res = 32'hcafe0001; mem_rf_waddr = 5'd11; mem_rf_we = 1'b1; mem_pc = 32'h80; mem_inst = 32'h1234abcd;
        i_wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_idle();
            i_wb_ready = 1'b0;
            if (k == 1) begin data_sram_data_ok = 1'b1; data_sram_rdata = 32'hbad0bad0; end
            #1;
            total++; if ({o_mem_ready, o_wb_valid, wb_rf_wdata, wb_rf_waddr, wb_pc, wb_inst} !== {1'b0, 1'b1, 32'hcafe0001, 5'd11, 32'h80, 32'h1234abcd}) begin
                bad++; $display("FAIL bp_hold_%0d ready=%b valid=%b wdata=%h waddr=%0d pc=%h inst=%h want 0 1 cafe0001 11 80 1234abcd",
                                k, o_mem_ready, o_wb_valid, wb_rf_wdata, wb_rf_waddr, wb_pc, wb_inst);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        total++; if ({o_mem_ready, o_wb_valid, wb_rf_wdata} !== {1'b1, 1'b1, 32'hcafe0001}) begin
            bad++; $display("FAIL bp_release ready=%b valid=%b wdata=%h want 1 1 cafe0001", o_mem_ready, o_wb_valid, wb_rf_wdata);
        end
        @(negedge clk);
        total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got %b want 0", o_wb_valid); end
    endtask

    // Model: the stage holds at most one instruction; tracks whether it is
    // resident, finished, and granted by the SRAM, plus a reference memory.
    task automatic test_random();
        logic        occ, done, is_mem, granted, chk_data, pend, got_data;
        logic        exp_valid, exp_req, exp_ready, exp_we, exp_wr;
        logic [31:0] exp_wdata, exp_pc, exp_inst, exp_addr, exp_sw, pend_data, resp;
        logic [4:0]  exp_waddr;
        logic [31:0] model_mem [16];
        logic [31:0] sram_mem [16];
        int          pend_delay, typ, cycles;
        for (int i = 0; i < 16; i++) begin model_mem[i] = $urandom; sram_mem[i] = model_mem[i]; end
        occ = 0; done = 0; is_mem = 0; granted = 0; chk_data = 0; pend = 0; exp_we = 0; exp_wr = 0;
        exp_wdata = '0; exp_pc = '0; exp_inst = '0; exp_addr = '0; exp_sw = '0; exp_waddr = '0;
        pend_data = '0; pend_delay = 0; cycles = 0;
        drive_idle();
        while (cycles < 700 && (cycles < 400 || occ)) begin
            @(negedge clk);
            exp_valid = occ && done;
            exp_req   = occ && is_mem && !granted;
            total++; if (o_wb_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid c=%0d got %b want %b", cycles, o_wb_valid, exp_valid); end
            total++; if (data_sram_req !== exp_req) begin bad++; $display("FAIL rnd_req c=%0d got %b want %b", cycles, data_sram_req, exp_req); end
            data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = $urandom; got_data = 1'b0;
            if (pend) begin
                if (pend_delay == 0) begin
                    data_sram_data_ok = 1'b1; data_sram_rdata = pend_data; pend = 1'b0; got_data = 1'b1;
                end else begin
                    pend_delay--;
                end
            end else if (data_sram_req && $urandom_range(0, 1) == 1) begin
                data_sram_addr_ok = 1'b1; granted = 1'b1;
                total++; if ({data_sram_addr, data_sram_wr, data_sram_wstrb, exp_wr ? data_sram_wdata : 32'h0} !==
                             {exp_addr, exp_wr, exp_wr ? 4'hf : 4'h0, exp_wr ? exp_sw : 32'h0}) begin
                    bad++; $display("FAIL rnd_sram_req c=%0d addr=%h wr=%b wstrb=%h wdata=%h want %h %b %h",
                                    cycles, data_sram_addr, data_sram_wr, data_sram_wstrb, data_sram_wdata, exp_addr, exp_wr, exp_sw);
                end
                resp = sram_mem[data_sram_addr[5:2]];
                if (data_sram_wr) sram_mem[data_sram_addr[5:2]] = data_sram_wdata;
                if ($urandom_range(0, 2) == 0) begin
                    data_sram_data_ok = 1'b1; data_sram_rdata = resp; got_data = 1'b1;
                end else begin
                    pend = 1'b1; pend_delay = $urandom_range(0, 2); pend_data = resp;
                end
            end else if (!data_sram_req) begin
                data_sram_addr_ok = ($urandom_range(0, 3) == 0);
            end
            typ = $urandom_range(0, 2);
            i_mem_valid      = (cycles < 400) && ($urandom_range(0, 3) != 0);
            mem_alu_res      = $urandom;
            mem_mem_wdata    = $urandom;
            mem_rf_waddr     = 5'($urandom);
            mem_rf_we        = 1'($urandom);
            mem_pc           = $urandom;
            mem_inst         = $urandom;
            mem_res_from_mem = (typ == 1);
            mem_mem_we       = (typ == 2);
            i_wb_ready       = (cycles >= 400) || ($urandom_range(0, 3) != 0);
            #1;
            if (got_data) done = 1'b1;
            exp_ready = !occ || (exp_valid && i_wb_ready);
            total++; if (o_mem_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready c=%0d got %b want %b", cycles, o_mem_ready, exp_ready); end
            if (exp_valid && i_wb_ready) begin
                total++; if ({wb_rf_waddr, wb_rf_we, wb_pc, wb_inst, chk_data ? wb_rf_wdata : 32'h0} !==
                             {exp_waddr, exp_we, exp_pc, exp_inst, chk_data ? exp_wdata : 32'h0}) begin
                    bad++; $display("FAIL rnd_wb c=%0d waddr=%0d we=%b pc=%h inst=%h wdata=%h want %0d %b %h %h %h",
                                    cycles, wb_rf_waddr, wb_rf_we, wb_pc, wb_inst, wb_rf_wdata, exp_waddr, exp_we, exp_pc, exp_inst, exp_wdata);
                end
                occ = 1'b0;
            end
            if (i_mem_valid && exp_ready) begin
                occ = 1'b1; granted = 1'b0; is_mem = (typ != 0); done = (typ == 0);
                exp_waddr = mem_rf_waddr; exp_pc = mem_pc; exp_inst = mem_inst;
                exp_addr = mem_alu_res; exp_sw = mem_mem_wdata; exp_wr = (typ == 2);
                exp_we = mem_rf_we && (typ != 2); chk_data = (typ != 2);
                if (typ == 1)      exp_wdata = model_mem[mem_alu_res[5:2]];
                else               exp_wdata = mem_alu_res;
                if (typ == 2) model_mem[mem_alu_res[5:2]] = mem_mem_wdata;
            end
            cycles++;
        end
        total++; if (occ) begin bad++; $display("FAIL rnd_drain instruction still resident after %0d cycles, want empty", cycles); end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
